mem_map_ctrl: RTL
=================

// Module: mem_map_ctrl
// PURPOSE
//  Parametrised successor to the core's address-region decoder. Decodes PC and data-address
//  upper nibbles into IMEM/DMEM/BIOS/IO, generates byte-lane write enables and aligned store
//  data, realigns load data, and runs a req/ack IO handshake with pipeline stall and timeout.
//  Sits between the 3-stage core's execute/writeback stages and the BRAMs/IO fabric.
// PARAMETERS
//  FETCH_BIOS_SEL  1    iload_sel value when fetching from BIOS (PC[31:28]=4'h4)
//  READ_BIOS_SEL   1    load source code for BIOS reads (DMEM reads use the inverse)
//  IMEM_WR_PC_BIT  2    bit of pc_upper that must be 1 to permit IMEM writes
//  IO_TIMEOUT      255  IO_WAIT cycles before abort; 0 disables the timeout
//  TIMEOUT_W       8    counter width, >= clog2(IO_TIMEOUT+1)
// PORTS
//  clk        in   1   core clock
//  rst        in   1   synchronous active-high reset
//  pc_upper   in   4   PC[31:28] of the fetch address
//  mem_addr   in   32  data address from execute
//  mem_wdata  in   32  store data from rs2
//  mem_re     in   1   load request
//  mem_we     in   1   store request
//  funct3     in   3   access size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU
//  dmem_dout  in   32  DMEM read data (1-cycle BRAM latency)
//  bios_dout  in   32  BIOS read data (1-cycle BRAM latency)
//  io_rdata   in   32  IO read data, valid with io_ack
//  io_ack     in   1   IO completion
//  iload_sel  out  1   registered fetch source select
//  imem_wea   out  4   IMEM byte write enables
//  dmem_wea   out  4   DMEM byte write enables
//  wdata_al   out  32  lane-replicated store data
//  load_data  out  32  aligned, sign/zero-extended load result
//  io_req     out  1   IO request, held until ack or timeout
//  io_we      out  1   IO write qualifier
//  io_addr    out  32  latched IO address
//  io_wdata   out  32  latched IO store data
//  stall      out  1   freeze core pipeline
//  misalign   out  1   1-cycle pulse after a misaligned access
//  io_timeout out  1   1-cycle pulse on IO abort
// BEHAVIOUR
//  - Reset: all outputs 0; FSM IDLE; timeout counter 0; load pipeline regs 0. Reset during
//    IO_WAIT drops io_req on the next edge; no ack is awaited after reset.
//  - Region decode on mem_addr[31:28]: 1=DMEM, 2=IMEM(wr only), 3=DMEM+IMEM(wr), 4=BIOS(rd only),
//    8=IO; others: no access, load_data 0, no enables. IMEM write needs pc_upper[IMEM_WR_PC_BIT].
//  - Stores (comb.): B lanes=1<<a[1:0]; H lanes=3<<a[1:0]; W lanes=4'hF. wdata_al replicates
//    byte x4 / half x2. H with a[0]=1 or W with a[1:0]!=0 is misaligned: enables forced 0.
//  - mem_re&mem_we together is treated as a store.
//  - iload_sel registered from pc_upper (4: FETCH_BIOS_SEL, 1: !FETCH_BIOS_SEL, else 0); holds while stall.
//  - Loads DMEM/BIOS: source, a[1:0], funct3 registered on mem_re; next cycle load_data mux/extract
//    from dmem_dout or bios_dout. Misaligned load returns 0.
//  - misalign pulses the cycle after any misaligned re/we; IO accesses also checked (no io_req then).
//  - IO FSM: IDLE -> IO_WAIT on aligned re/we to region 8; stall=1 combinationally that cycle;
//    addr/wdata/we latched, io_req=1 from next cycle. IO_WAIT: stall=1, counter++; io_ack ->
//    capture io_rdata (aligned as loads), go IO_DONE; counter==IO_TIMEOUT-1 without ack ->
//    io_timeout pulse, data 0, IO_DONE. Ack on the timeout cycle wins. IO_DONE: stall=0,
//    io_req=0, load_data = captured data for one cycle, -> IDLE. Stores: same flow, no data.
//  - Late io_ack seen in IDLE/IO_DONE is ignored.
// STRUCTURE
//  - Package mem_map_pkg: region nibble constants, funct3 encodings, FSM state encodings
//    (IDLE/IO_WAIT/IO_DONE), lane-mask helper function.
//  - One sub-module mem_load_align: (data, offset, funct3) -> extended 32-bit, used for BRAM and IO paths.
// TESTING
//  - SB addr 0x1000_0003 data 0xAB, pc_upper 4 -> dmem_wea 4'b1000, wdata_al 0xABABABAB, imem_wea 0.
//  - SW addr 0x2000_0000, pc_upper 1 -> imem_wea 0; pc_upper 4 -> imem_wea 4'hF; addr 0x3.. -> both F.
//  - LB addr 0x4000_0002, bios_dout 0x0080_0000 next cycle -> load_data 0xFFFF_FF80; LBU -> 0x80.
//  - SH addr 0x1000_0001 -> dmem_wea 0, misalign pulse 1 cycle later, no other side effect.
//  - LW addr 0x8000_0010, io_ack after 3 cycles with 0x1234_5678 -> stall 4 cycles, io_req held,
//    load_data 0x1234_5678 in IO_DONE, stall 0 that cycle.
//  - IO_TIMEOUT=4, no ack -> io_timeout pulse, load_data 0, stall released; rst in IO_WAIT -> all 0.

Source files
------------

// File: rtl/mem_map_pkg.sv
// Shared constants and helpers for the memory-map controller: region nibbles, access
// encodings, IO handshake states and store lane masks.
package mem_map_pkg;

    localparam logic [3:0] REGION_DMEM = 4'h1;
    localparam logic [3:0] REGION_IMEM = 4'h2;
    localparam logic [3:0] REGION_DMIM = 4'h3;
    localparam logic [3:0] REGION_BIOS = 4'h4;
    localparam logic [3:0] REGION_IO   = 4'h8;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StIoWait = 2'd1,
        StIoDone = 2'd2
    } io_state_e;

    // Size lives in funct3[1:0]; the sign bit funct3[2] does not affect lanes.
    function automatic logic [3:0] lane_mask(input logic [2:0] f3, input logic [1:0] off);
        case (f3[1:0])
            2'b00:   lane_mask = 4'b0001 << off;
            2'b01:   lane_mask = 4'b0011 << off;
            2'b10:   lane_mask = 4'b1111;
            default: lane_mask = 4'b0000;
        endcase
    endfunction

    function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] off);
        is_misaligned = ((f3[1:0] == 2'b01) && off[0]) ||
                        ((f3[1:0] == 2'b10) && (off != 2'b00));
    endfunction

endpackage

// File: rtl/mem_load_align.sv
// Extracts a byte/half/word from a 32-bit read word at the given offset and sign- or
// zero-extends it according to funct3. Shared by the BRAM and IO read paths.
module mem_load_align
    import mem_map_pkg::*;
(
    input  logic [31:0] i_data,
    input  logic [1:0]  i_offset,
    input  logic [2:0]  i_funct3,
    output logic [31:0] o_data
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        w_byte = i_data[7:0];
        case (i_offset)
            2'd0:    w_byte = i_data[7:0];
            2'd1:    w_byte = i_data[15:8];
            2'd2:    w_byte = i_data[23:16];
            default: w_byte = i_data[31:24];
        endcase
        w_half = i_offset[1] ? i_data[31:16] : i_data[15:0];
    end

    always_comb begin
        o_data = '0;
        case (i_funct3)
            F3_B:    o_data = {{24{w_byte[7]}}, w_byte};
            F3_H:    o_data = {{16{w_half[15]}}, w_half};
            F3_W:    o_data = i_data;
            F3_BU:   o_data = {24'b0, w_byte};
            F3_HU:   o_data = {16'b0, w_half};
            default: o_data = '0;
        endcase
    end

endmodule

// File: rtl/mem_map_ctrl.sv
// Address-region decoder between the core and BRAM/IO: byte-lane store enables, load
// realignment, and a req/ack IO handshake that stalls the pipeline with a timeout.
module mem_map_ctrl
    import mem_map_pkg::*;
#(
    parameter bit          FETCH_BIOS_SEL = 1'b1,
    parameter bit          READ_BIOS_SEL  = 1'b1,
    parameter int unsigned IMEM_WR_PC_BIT = 2,
    parameter int unsigned IO_TIMEOUT     = 255,
    parameter int unsigned TIMEOUT_W      = 8
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [3:0]  i_pc_upper,
    input  logic [31:0] i_mem_addr,
    input  logic [31:0] i_mem_wdata,
    input  logic        i_mem_re,
    input  logic        i_mem_we,
    input  logic [2:0]  i_funct3,
    input  logic [31:0] i_dmem_dout,
    input  logic [31:0] i_bios_dout,
    input  logic [31:0] i_io_rdata,
    input  logic        i_io_ack,
    output logic        o_iload_sel,
    output logic [3:0]  o_imem_wea,
    output logic [3:0]  o_dmem_wea,
    output logic [31:0] o_wdata_al,
    output logic [31:0] o_load_data,
    output logic        o_io_req,
    output logic        o_io_we,
    output logic [31:0] o_io_addr,
    output logic [31:0] o_io_wdata,
    output logic        o_stall,
    output logic        o_misalign,
    output logic        o_io_timeout
);

    localparam int unsigned TO_LAST_I = (IO_TIMEOUT == 0) ? 0 : IO_TIMEOUT - 1;
    localparam logic [TIMEOUT_W-1:0] TO_LAST = TO_LAST_I[TIMEOUT_W-1:0];
    localparam bit TO_EN = (IO_TIMEOUT != 0);

    io_state_e            r_state;
    logic [TIMEOUT_W-1:0] r_cnt;
    logic                 r_io_req;
    logic                 r_io_we;
    logic [31:0]          r_io_addr;
    logic [31:0]          r_io_wdata;
    logic [2:0]           r_io_f3;
    logic [31:0]          r_io_data;
    logic                 r_io_timeout;
    logic                 r_iload_sel;
    logic                 r_misalign;
    logic                 r_ld_valid;
    logic                 r_ld_src;
    logic [1:0]           r_ld_off;
    logic [2:0]           r_ld_f3;

    logic [3:0]  w_region;
    logic [1:0]  w_off;
    logic        w_mis;
    logic        w_access;
    logic        w_is_ld;
    logic [3:0]  w_lanes;
    logic        w_dmem_rgn;
    logic        w_imem_rgn;
    logic        w_io_start;
    logic        w_stall;
    logic [31:0] w_wdata_al;
    logic [31:0] w_ld_raw;
    logic [31:0] w_ld_aligned;
    logic [31:0] w_io_aligned;

    assign w_region   = i_mem_addr[31:28];
    assign w_off      = i_mem_addr[1:0];
    assign w_mis      = is_misaligned(i_funct3, w_off);
    assign w_access   = i_mem_re | i_mem_we;
    assign w_is_ld    = i_mem_re & ~i_mem_we;
    assign w_lanes    = lane_mask(i_funct3, w_off);
    assign w_dmem_rgn = (w_region == REGION_DMEM) || (w_region == REGION_DMIM);
    assign w_imem_rgn = (w_region == REGION_IMEM) || (w_region == REGION_DMIM);
    assign w_io_start = (r_state == StIdle) && w_access && (w_region == REGION_IO) && !w_mis;
    assign w_stall    = !i_rst && ((r_state == StIoWait) || w_io_start);

    always_comb begin
        case (i_funct3[1:0])
            2'b00:   w_wdata_al = {4{i_mem_wdata[7:0]}};
            2'b01:   w_wdata_al = {2{i_mem_wdata[15:0]}};
            default: w_wdata_al = i_mem_wdata;
        endcase
    end

    always_comb begin
        o_dmem_wea = '0;
        o_imem_wea = '0;
        o_wdata_al = '0;
        if (!i_rst) begin
            o_wdata_al = w_wdata_al;
            if (i_mem_we && !w_mis) begin
                if (w_dmem_rgn) o_dmem_wea = w_lanes;
                if (w_imem_rgn && i_pc_upper[IMEM_WR_PC_BIT]) o_imem_wea = w_lanes;
            end
        end
    end

    assign w_ld_raw = (r_ld_src == READ_BIOS_SEL) ? i_bios_dout : i_dmem_dout;

    mem_load_align u_ld_align (
        .i_data   (w_ld_raw),
        .i_offset (r_ld_off),
        .i_funct3 (r_ld_f3),
        .o_data   (w_ld_aligned)
    );

    mem_load_align u_io_align (
        .i_data   (i_io_rdata),
        .i_offset (r_io_addr[1:0]),
        .i_funct3 (r_io_f3),
        .o_data   (w_io_aligned)
    );

    always_comb begin
        o_load_data = '0;
        if (!i_rst) begin
            if (r_state == StIoDone) o_load_data = r_io_data;
            else if (r_ld_valid)     o_load_data = w_ld_aligned;
        end
    end

    // BRAM loads: capture source/offset/size now, the BRAM word arrives next cycle.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_ld_valid  <= 1'b0;
            r_ld_src    <= 1'b0;
            r_ld_off    <= '0;
            r_ld_f3     <= '0;
            r_misalign  <= 1'b0;
            r_iload_sel <= 1'b0;
        end else begin
            r_ld_valid <= w_is_ld && !w_mis && (w_dmem_rgn || (w_region == REGION_BIOS));
            r_ld_src   <= (w_region == REGION_BIOS) ? READ_BIOS_SEL : !READ_BIOS_SEL;
            r_ld_off   <= w_off;
            r_ld_f3    <= i_funct3;
            r_misalign <= w_access && w_mis;
            if (!w_stall) begin
                if (i_pc_upper == REGION_BIOS)      r_iload_sel <= FETCH_BIOS_SEL;
                else if (i_pc_upper == REGION_DMEM) r_iload_sel <= !FETCH_BIOS_SEL;
                else                                r_iload_sel <= 1'b0;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state      <= StIdle;
            r_cnt        <= '0;
            r_io_req     <= 1'b0;
            r_io_we      <= 1'b0;
            r_io_addr    <= '0;
            r_io_wdata   <= '0;
            r_io_f3      <= '0;
            r_io_data    <= '0;
            r_io_timeout <= 1'b0;
        end else begin
            r_io_timeout <= 1'b0;
            case (r_state)
                StIdle: begin
                    if (w_io_start) begin
                        r_state    <= StIoWait;
                        r_cnt      <= '0;
                        r_io_req   <= 1'b1;
                        r_io_we    <= i_mem_we;
                        r_io_addr  <= i_mem_addr;
                        r_io_wdata <= w_wdata_al;
                        r_io_f3    <= i_funct3;
                        r_io_data  <= '0;
                    end
                end
                StIoWait: begin
                    r_cnt <= r_cnt + 1'b1;
                    // An ack arriving on the timeout cycle takes priority over the abort.
                    if (i_io_ack) begin
                        r_io_data <= r_io_we ? 32'h0 : w_io_aligned;
                        r_io_req  <= 1'b0;
                        r_io_we   <= 1'b0;
                        r_state   <= StIoDone;
                    end else if (TO_EN && (r_cnt == TO_LAST)) begin
                        r_io_timeout <= 1'b1;
                        r_io_data    <= '0;
                        r_io_req     <= 1'b0;
                        r_io_we      <= 1'b0;
                        r_state      <= StIoDone;
                    end
                end
                StIoDone: r_state <= StIdle;
                default:  r_state <= StIdle;
            endcase
        end
    end

    assign o_iload_sel  = r_iload_sel;
    assign o_io_req     = r_io_req;
    assign o_io_we      = r_io_we;
    assign o_io_addr    = r_io_addr;
    assign o_io_wdata   = r_io_wdata;
    assign o_stall      = w_stall;
    assign o_misalign   = r_misalign;
    assign o_io_timeout = r_io_timeout;

endmodule
